// File: rtl/serial_mult_pkg.sv
// rtl/serial_mult_pkg.sv - shared FSM state type and operand/result widths for serial_mult and its driver
package serial_mult_pkg;

    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_A = 3'd1,
        ST_SEND_B = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/serial_mult_driver.sv
// rtl/serial_mult_driver.sv - host request/response front end feeding bytes to serial_mult; optional WAIT watchdog via SERIAL_MULT_DRV_TIMEOUT_EN
module serial_mult_driver
    import serial_mult_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OPERAND_W-1:0] req_a,
    input  logic [OPERAND_W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RESULT_W-1:0]  rsp_data,
    output logic                 rsp_err,
    output logic                 put,
    output logic [OPERAND_W-1:0] idata,
    input  logic                 ready,
    output logic                 get,
    input  logic                 result_valid,
    input  logic [RESULT_W-1:0]  result
);

    state_t               state, state_nxt;
    logic [OPERAND_W-1:0] op_a, op_b;
    logic                 timeout;

`ifdef SERIAL_MULT_DRV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // A result arriving in the same cycle as the limit takes priority.
    assign timeout = (state == ST_WAIT) && !result_valid &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state == ST_SEND_B && ready) begin
                cnt <= '0;
            end else if (state == ST_WAIT && !result_valid) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == ST_WAIT && result_valid) begin
                rsp_err <= 1'b0;
            end else if (timeout) begin
                rsp_err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid)               state_nxt = ST_SEND_A;
            ST_SEND_A: if (ready)                   state_nxt = ST_SEND_B;
            ST_SEND_B: if (ready)                   state_nxt = ST_WAIT;
            ST_WAIT:   if (result_valid || timeout) state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready)               state_nxt = ST_IDLE;
            default:                                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        put       = 1'b0;
        get       = 1'b0;
        idata     = '0;
        case (state)
            ST_IDLE:   req_ready = 1'b1;
            ST_SEND_A: begin
                put   = ready;
                idata = op_a;
            end
            ST_SEND_B: begin
                put   = ready;
                idata = op_b;
            end
            ST_WAIT:   get       = result_valid;
            ST_RESP:   rsp_valid = 1'b1;
            default:   req_ready = 1'b0;
        endcase
    end

    // Operands and the product are held in registers so the host side sees stable values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            rsp_data <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                op_a <= req_a;
                op_b <= req_b;
            end
            if (state == ST_WAIT && result_valid) begin
                rsp_data <= result;
            end else if (timeout) begin
                rsp_data <= '1;
            end
        end
    end

endmodule
